// File: rtl/lcd_pkg.sv
// lcd_pkg: command codes, FSM encoding and error width for the LCD command sequencer.
// Defining LCD_CMD_SEQ_FILTER_EN widens err by one illegal-command bit.
package lcd_pkg;
  localparam logic [3:0] CMD_WRITE     = 4'd0;
  localparam logic [3:0] CMD_CLEAR     = 4'd1;
  localparam logic [3:0] CMD_HOME      = 4'd2;
  localparam logic [3:0] CMD_ENTRY     = 4'd3;
  localparam logic [3:0] CMD_DISPLAY   = 4'd4;
  localparam logic [3:0] CMD_SHIFT     = 4'd5;
  localparam logic [3:0] CMD_FUNC      = 4'd6;
  localparam logic [3:0] CMD_CGRAM     = 4'd7;
  localparam logic [3:0] CMD_DDRAM     = 4'd8;
  localparam logic [3:0] CMD_READ      = 4'd9;
  localparam logic [3:0] CMD_BUSY_POLL = 4'd10;
  localparam logic [3:0] CMD_INIT      = 4'd11;
  localparam logic [3:0] DEF_CMD_MAX   = CMD_INIT;
`ifdef LCD_CMD_SEQ_FILTER_EN
  localparam int ERR_W = 3;
  localparam bit FILTER = 1'b1;
`else
  localparam int ERR_W = 2;
  localparam bit FILTER = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, WAIT_READY, ISSUE, WAIT_ACK, WAIT_DONE, HALT} state_t;
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: command FIFO; a pop needs a non-empty FIFO, a push into a full FIFO needs a same-cycle pop.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] din,
  input  logic       push,
  input  logic       pop,
  output logic [3:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= do_push ? wr + 1'b1 : wr;
      rd <= do_pop ? rd + 1'b1 : rd;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: queues host commands and issues them one at a time under LCD busy/done handshake.
// Optional LCD_CMD_SEQ_FILTER_EN rejects codes above CMD_MAX and flags them in err[2].
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int         DEPTH       = 8,
  parameter logic [3:0] CMD_MAX     = DEF_CMD_MAX,
  parameter int         ACK_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       host_cmd,
  input  logic             host_push,
  output logic             host_full,
  input  logic             lcd_busy,
  input  logic             lcd_done,
  output logic [3:0]       cmd,
  output logic             cmd_valid,
  output logic             seq_idle,
  output logic [ERR_W-1:0] err,
  output logic [7:0]       issued_cnt
);
  state_t state, nxt;
  logic [7:0] tmr;
  logic [3:0] head;
  logic empty, legal, issue, tmo, ovf;
  logic [ERR_W-1:0] err_set;
  assign legal = !FILTER || host_cmd <= CMD_MAX;
  // busy rising in the ISSUE cycle itself defers the issue rather than colliding with it
  assign issue = state == ISSUE && !lcd_busy && !lcd_done;
  assign tmo = state == WAIT_ACK && !lcd_busy && !lcd_done && tmr == 8'(ACK_TIMEOUT - 1);
  assign ovf = host_push && legal && host_full && !issue;
`ifdef LCD_CMD_SEQ_FILTER_EN
  assign err_set = {host_push && !legal, tmo, ovf};
`else
  assign err_set = {tmo, ovf};
`endif
  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .din(host_cmd),
    .push(host_push && legal),
    .pop(issue),
    .head(head),
    .full(host_full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = empty ? IDLE : WAIT_READY;
      WAIT_READY: nxt = lcd_busy ? WAIT_READY : ISSUE;
      ISSUE:      nxt = lcd_busy ? WAIT_READY : WAIT_ACK;
      WAIT_ACK:   nxt = lcd_busy ? WAIT_DONE : tmo ? IDLE : WAIT_ACK;
      WAIT_DONE:  nxt = lcd_busy ? WAIT_DONE : empty ? IDLE : WAIT_READY;
      default:    nxt = HALT;
    endcase
    if (lcd_done) nxt = HALT;
  end
  always_comb begin
    cmd_valid = issue;
    seq_idle = state == IDLE && empty;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cmd <= '0;
      err <= '0;
      issued_cnt <= '0;
      tmr <= '0;
    end else begin
      cmd <= state == WAIT_READY && nxt == ISSUE ? head : cmd;
      err <= err | err_set;
      issued_cnt <= issue ? issued_cnt + 8'd1 : issued_cnt;
      tmr <= state == WAIT_ACK ? tmr + 8'd1 : 8'd0;
    end
endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb_lcd_cmd_seq: directed scenario tasks with hand-computed expectations for lcd_cmd_seq.
module tb_lcd_cmd_seq;
  import lcd_pkg::*;
  logic clk = 1'b0;
  logic reset, host_push, host_full, lcd_busy, lcd_done, cmd_valid, seq_idle;
  logic [3:0] host_cmd, cmd;
  logic [ERR_W-1:0] err;
  logic [7:0] issued_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_cmd_seq dut (
    .clk(clk),
    .reset(reset),
    .host_cmd(host_cmd),
    .host_push(host_push),
    .host_full(host_full),
    .lcd_busy(lcd_busy),
    .lcd_done(lcd_done),
    .cmd(cmd),
    .cmd_valid(cmd_valid),
    .seq_idle(seq_idle),
    .err(err),
    .issued_cnt(issued_cnt)
  );

  task step;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    reset = 1'b0;
    host_push = 1'b0;
    host_cmd = 4'd0;
    lcd_busy = 1'b0;
    lcd_done = 1'b0;
    step;
    step;
    reset = 1'b1;
  endtask

  task test_reset;
    do_reset;
    checks++; if (host_full !== 1'b0) begin errors++; $display("FAIL reset_host_full got %b want 0", host_full); end
    checks++; if (seq_idle !== 1'b1) begin errors++; $display("FAIL reset_seq_idle got %b want 1", seq_idle); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
    checks++; if (cmd !== 4'd0) begin errors++; $display("FAIL reset_cmd got %0d want 0", cmd); end
    checks++; if (err[1:0] !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", err[1:0]); end
    checks++; if (issued_cnt !== 8'd0) begin errors++; $display("FAIL reset_issued_cnt got %0d want 0", issued_cnt); end
  endtask

  task test_latency;
    do_reset;
    host_cmd = 4'd3;
    host_push = 1'b1;
    step;
    host_push = 1'b0;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL lat_early got %b want 0", cmd_valid); end
    step;
    step;
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL lat_cmd_valid got %b want 1", cmd_valid); end
    checks++; if (cmd !== 4'd3) begin errors++; $display("FAIL lat_cmd got %0d want 3", cmd); end
    step;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL lat_one_cycle got %b want 0", cmd_valid); end
    checks++; if (issued_cnt !== 8'd1) begin errors++; $display("FAIL lat_issued_cnt got %0d want 1", issued_cnt); end
    checks++; if (cmd !== 4'd3) begin errors++; $display("FAIL lat_cmd_hold got %0d want 3", cmd); end
    lcd_busy = 1'b1;
    step;
    lcd_busy = 1'b0;
    step;
    checks++; if (seq_idle !== 1'b1) begin errors++; $display("FAIL lat_back_idle got %b want 1", seq_idle); end
    checks++; if (err[1:0] !== 2'b00) begin errors++; $display("FAIL lat_err got %b want 00", err[1:0]); end
  endtask

  task test_full;
    logic [3:0] got [8];
    int n, ph;
    do_reset;
    lcd_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_cmd = 4'(i + 1);
      host_push = 1'b1;
      step;
    end
    checks++; if (host_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", host_full); end
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL full_no_ovf got %b want 0", err[0]); end
    host_cmd = 4'd9;
    step;
    host_push = 1'b0;
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL full_ovf got %b want 1", err[0]); end
    lcd_busy = 1'b0;
    n = 0;
    ph = 0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      step;
      if (cmd_valid) begin
        got[n] = cmd;
        n++;
        ph = 1;
      end else if (ph == 1) begin
        lcd_busy = 1'b1;
        ph = 2;
      end else if (ph == 2) begin
        lcd_busy = 1'b0;
        ph = 0;
      end
    end
    checks++; if (n != 8) begin errors++; $display("FAIL full_issue_count got %0d want 8", n); end
    for (int k = 0; k < n; k++) begin
      checks++; if (got[k] !== 4'(k + 1)) begin errors++; $display("FAIL full_order[%0d] got %0d want %0d", k, got[k], k + 1); end
    end
    step;
    checks++; if (issued_cnt !== 8'd8) begin errors++; $display("FAIL full_issued_cnt got %0d want 8", issued_cnt); end
    checks++; if (err[1] !== 1'b0) begin errors++; $display("FAIL full_no_tmo got %b want 0", err[1]); end
  endtask

  task test_timeout;
    do_reset;
    host_cmd = 4'd5;
    host_push = 1'b1;
    step;
    host_cmd = 4'd6;
    step;
    host_push = 1'b0;
    step;
    checks++; if (cmd_valid !== 1'b1 || cmd !== 4'd5) begin errors++; $display("FAIL tmo_first got v=%b c=%0d want v=1 c=5", cmd_valid, cmd); end
    repeat (4) step;
    checks++; if (err[1] !== 1'b0) begin errors++; $display("FAIL tmo_early got %b want 0", err[1]); end
    step;
    checks++; if (err[1] !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b want 1", err[1]); end
    checks++; if (seq_idle !== 1'b0) begin errors++; $display("FAIL tmo_seq_idle got %b want 0", seq_idle); end
    step;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL tmo_gap got %b want 0", cmd_valid); end
    step;
    checks++; if (cmd_valid !== 1'b1 || cmd !== 4'd6) begin errors++; $display("FAIL tmo_next got v=%b c=%0d want v=1 c=6", cmd_valid, cmd); end
  endtask

  task test_halt;
    int seen;
    do_reset;
    host_cmd = 4'd1;
    host_push = 1'b1;
    step;
    host_cmd = 4'd2;
    step;
    host_push = 1'b0;
    step;
    checks++; if (cmd_valid !== 1'b1 || cmd !== 4'd1) begin errors++; $display("FAIL halt_first got v=%b c=%0d want v=1 c=1", cmd_valid, cmd); end
    step;
    lcd_busy = 1'b1;
    step;
    lcd_done = 1'b1;
    step;
    lcd_done = 1'b0;
    lcd_busy = 1'b0;
    seen = 0;
    repeat (20) begin
      step;
      if (cmd_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL halt_no_issue got %0d issues want 0", seen); end
    checks++; if (seq_idle !== 1'b0) begin errors++; $display("FAIL halt_seq_idle got %b want 0", seq_idle); end
    checks++; if (issued_cnt !== 8'd1) begin errors++; $display("FAIL halt_issued_cnt got %0d want 1", issued_cnt); end
    host_cmd = 4'd0;
    host_push = 1'b1;
    repeat (6) step;
    checks++; if (host_full !== 1'b0) begin errors++; $display("FAIL halt_not_full got %b want 0", host_full); end
    step;
    host_push = 1'b0;
    checks++; if (host_full !== 1'b1) begin errors++; $display("FAIL halt_fills got %b want 1", host_full); end
  endtask

  task test_reset_mid;
    int seen;
    do_reset;
    host_cmd = 4'd4;
    host_push = 1'b1;
    step;
    host_push = 1'b0;
    step;
    step;
    checks++; if (cmd_valid !== 1'b1 || cmd !== 4'd4) begin errors++; $display("FAIL rmid_issue got v=%b c=%0d want v=1 c=4", cmd_valid, cmd); end
    reset = 1'b0;
    #1;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rmid_async got %b want 0", cmd_valid); end
    step;
    checks++; if (cmd !== 4'd0) begin errors++; $display("FAIL rmid_cmd got %0d want 0", cmd); end
    checks++; if (issued_cnt !== 8'd0) begin errors++; $display("FAIL rmid_issued_cnt got %0d want 0", issued_cnt); end
    checks++; if (err[1:0] !== 2'b00) begin errors++; $display("FAIL rmid_err got %b want 00", err[1:0]); end
    checks++; if (seq_idle !== 1'b1) begin errors++; $display("FAIL rmid_seq_idle got %b want 1", seq_idle); end
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      step;
      if (cmd_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_issue got %0d issues want 0", seen); end
  endtask

  task test_illegal;
    int seen;
    logic [3:0] last;
    do_reset;
    host_cmd = 4'd13;
    host_push = 1'b1;
    step;
    host_push = 1'b0;
    seen = 0;
    last = 4'd0;
    repeat (10) begin
      step;
      if (cmd_valid) begin
        seen++;
        last = cmd;
      end
    end
`ifdef LCD_CMD_SEQ_FILTER_EN
    checks++; if (seen != 0) begin errors++; $display("FAIL ill_dropped got %0d issues want 0", seen); end
    checks++; if (err[2] !== 1'b1) begin errors++; $display("FAIL ill_flag got %b want 1", err[2]); end
`else
    checks++; if (seen != 1) begin errors++; $display("FAIL ill_issued got %0d issues want 1", seen); end
    checks++; if (last !== 4'd13) begin errors++; $display("FAIL ill_cmd got %0d want 13", last); end
`endif
  endtask

  initial begin
    test_reset;
    test_latency;
    test_full;
    test_timeout;
    test_halt;
    test_reset_mid;
    test_illegal;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_cmd_seq.md
LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 Parameter DEPTH, default 8, command FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter CMD_MAX, default 4'd11, highest legal LCD command code.
REQ-003 Parameter ACK_TIMEOUT, default 4, cycles allowed for busy to rise after an issue.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 host_cmd  input  4  command code offered by host.
REQ-007 host_push  input  1  host write strobe; host_cmd is captured when high and accepted.
REQ-008 host_full  output  1  FIFO full.
REQ-009 lcd_busy  input  1  busy from the downstream LCD controller.
REQ-010 lcd_done  input  1  done from the downstream LCD controller.
REQ-011 cmd  output  4  command presented to the LCD controller.
REQ-012 cmd_valid  output  1  one-cycle issue strobe to the LCD controller.
REQ-013 seq_idle  output  1  high in IDLE with FIFO empty.
REQ-014 err  output  2  sticky flags: bit0 FIFO overflow, bit1 ack timeout.
REQ-015 issued_cnt  output  8  number of commands issued, wraps 255->0.

Function
REQ-016 FIFO accepts a push when not full, or when full and a pop occurs in the same cycle.
REQ-017 Push while full without a same-cycle pop is dropped and sets err[0].
REQ-018 Push and pop in the same cycle on an empty FIFO: the push is stored and the pop does not occur (a pop needs a non-empty FIFO at the start of the cycle).
REQ-019 FSM states: IDLE, WAIT_READY, ISSUE, WAIT_ACK, WAIT_DONE, HALT.
REQ-020 IDLE -> WAIT_READY when the FIFO is non-empty.
REQ-021 WAIT_READY -> ISSUE in the first cycle lcd_busy is 0.
REQ-022 ISSUE: cmd_valid = 1 for exactly one cycle, cmd = FIFO head; head is popped; issued_cnt increments; -> WAIT_ACK.
REQ-023 cmd is registered and holds its last issued value while cmd_valid is 0.
REQ-024 WAIT_ACK -> WAIT_DONE when lcd_busy = 1.
REQ-025 WAIT_ACK -> IDLE when ACK_TIMEOUT cycles elapse without lcd_busy; this sets err[1].
REQ-026 WAIT_DONE -> WAIT_READY when lcd_busy = 0 and the FIFO is non-empty.
REQ-027 WAIT_DONE -> IDLE when lcd_busy = 0 and the FIFO is empty.
REQ-028 lcd_done = 1 in any state -> HALT; this takes priority over all other transitions.
REQ-029 HALT: no further issues; pushes still fill the FIFO; exit only by reset.
REQ-030 cmd_valid is never asserted while lcd_busy is sampled high in the same cycle.
REQ-031 Issue latency, from a push into an empty FIFO with lcd_busy low, to cmd_valid: 2 cycles.

Reset
REQ-032 Reset assertion immediately clears the FIFO, forces FSM to IDLE, and zeroes cmd, cmd_valid, err and issued_cnt.
REQ-033 Reset values: host_full = 0, seq_idle = 1.
REQ-034 Reset mid-issue discards the in-flight command; no cmd_valid follows deassertion unless new pushes occur.

Configuration
REQ-035 With LCD_CMD_SEQ_FILTER_EN defined, a push with host_cmd > CMD_MAX is not stored and sets err bit; err widens to 3 bits, bit2 = illegal command.
REQ-036 Without LCD_CMD_SEQ_FILTER_EN, all codes are stored and issued unchanged, and err is 2 bits.

Structure
REQ-037 Shared package lcd_pkg holds the command code constants (WRITE = 0 through CMD_MAX), the FSM state encoding, and the default CMD_MAX.
REQ-038 FIFO storage and pointers are in sub-module lcd_cmd_fifo; lcd_cmd_seq holds the FSM, counters and flags.

Verification
REQ-039 Push 3 (cycle 0), lcd_busy low -> cmd_valid = 1 with cmd = 3 at cycle 2; issued_cnt = 1.
REQ-040 Push 8 commands with lcd_busy held high -> host_full = 1; 9th push sets err[0]; after busy falls, 8 commands are issued in push order.
REQ-041 Issue, then lcd_busy stays low for 4 cycles -> err[1] = 1, FSM returns to IDLE, next FIFO entry is issued afterwards.
REQ-042 Push 1,2 then lcd_done pulse during WAIT_DONE of command 1 -> command 2 is never issued, seq_idle = 0.
REQ-043 Reset asserted the same cycle as cmd_valid -> all outputs zero next edge, FIFO empty, issued_cnt = 0.
REQ-044 With LCD_CMD_SEQ_FILTER_EN, push 4'd13 -> not issued, err[2] = 1; without the macro -> cmd = 13 is issued.
